// File: rtl/accumulator_win.sv
// Windowed accumulator: sums COUNT_N accepted samples, then hands the
// window total out on a valid/ready port while the next window starts.
module accumulator_win #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 12,
  parameter int COUNT_N = 9,
  parameter bit SIGNED  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       sat_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            acc_in,
  output logic [ACC_W-1:0]           acc_run,
  output logic [$clog2(COUNT_N)-1:0] count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           acc_out,
  output logic                       ovf
);

  localparam int CW = $clog2(COUNT_N);
  localparam int XW = ACC_W + 1 - IN_W;
  localparam logic [CW-1:0] LAST = CW'(COUNT_N - 1);

  logic [ACC_W:0]   in_x;
  logic [ACC_W:0]   run_x;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] lim;
  logic [ACC_W-1:0] res;
  logic             ovf_now;
  logic             last;
  logic             accept;
  logic             close;
  logic             sticky;

  assign last     = (count == LAST);
  assign in_ready = ~(out_valid & ~out_ready & last);
  assign accept   = in_valid & in_ready;
  assign close    = accept & ~clear & last;

  // One guard bit is enough: two in-range ACC_W operands never
  // overflow ACC_W+1, so the top two bits expose any overflow.
  always_comb begin
    in_x  = SIGNED ? {{XW{acc_in[IN_W-1]}}, acc_in}
                   : {{XW{1'b0}}, acc_in};
    run_x = SIGNED ? {acc_run[ACC_W-1], acc_run}
                   : {1'b0, acc_run};
    sum   = run_x + in_x;
    ovf_now = SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1])
                     : sum[ACC_W];
    if (!SIGNED)
      lim = '1;
    else if (sum[ACC_W])
      lim = {1'b1, {(ACC_W-1){1'b0}}};
    else
      lim = {1'b0, {(ACC_W-1){1'b1}}};
    res = (ovf_now & sat_en) ? lim : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_run <= '0;
      count   <= '0;
      sticky  <= 1'b0;
    end else if (clear) begin
      acc_run <= '0;
      count   <= '0;
      sticky  <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc_run <= '0;
        count   <= '0;
        sticky  <= 1'b0;
      end else begin
        acc_run <= res;
        count   <= count + CW'(1);
        sticky  <= sticky | ovf_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      acc_out   <= '0;
      ovf       <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      acc_out   <= res;
      ovf       <= sticky | ovf_now;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accumulator_win.sv
// Bench for accumulator_win: three parameter sets, expected window
// results queued at stimulus time and popped on each output handshake.
module tb_accumulator_win;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       sat_en;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] acc_in;
  int         sel;

  logic        ir_d, ov_d, of_d;
  logic [11:0] ar_d, ao_d;
  logic [3:0]  cnt_d;
  logic        ir_w, ov_w, of_w;
  logic [7:0]  ar_w, ao_w;
  logic [3:0]  cnt_w;
  logic        ir_s, ov_s, of_s;
  logic [7:0]  ar_s, ao_s;
  logic [3:0]  cnt_s;

  logic iv_d, iv_w, iv_s;
  logic cl_d, cl_w, cl_s;
  logic cur_ready;

  logic [12:0] q_d[$];
  logic [12:0] q_w[$];
  logic [12:0] q_s[$];

  int n_checks;
  int n_errors;

  assign iv_d = in_valid & (sel == 0);
  assign iv_w = in_valid & (sel == 1);
  assign iv_s = in_valid & (sel == 2);
  assign cl_d = clear & (sel == 0);
  assign cl_w = clear & (sel == 1);
  assign cl_s = clear & (sel == 2);

  always_comb begin
    cur_ready = ir_d;
    if (sel == 1) cur_ready = ir_w;
    if (sel == 2) cur_ready = ir_s;
  end

  accumulator_win u_d (
    .clk(clk), .rst(rst), .clear(cl_d), .sat_en(sat_en),
    .in_valid(iv_d), .in_ready(ir_d), .acc_in(acc_in),
    .acc_run(ar_d), .count(cnt_d), .out_valid(ov_d),
    .out_ready(out_ready), .acc_out(ao_d), .ovf(of_d)
  );

  accumulator_win #(.IN_W(8), .ACC_W(8), .COUNT_N(9), .SIGNED(0)) u_w (
    .clk(clk), .rst(rst), .clear(cl_w), .sat_en(sat_en),
    .in_valid(iv_w), .in_ready(ir_w), .acc_in(acc_in),
    .acc_run(ar_w), .count(cnt_w), .out_valid(ov_w),
    .out_ready(out_ready), .acc_out(ao_w), .ovf(of_w)
  );

  accumulator_win #(.IN_W(8), .ACC_W(8), .COUNT_N(9), .SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .clear(cl_s), .sat_en(sat_en),
    .in_valid(iv_s), .in_ready(ir_s), .acc_in(acc_in),
    .acc_run(ar_s), .count(cnt_s), .out_valid(ov_s),
    .out_ready(out_ready), .acc_out(ao_s), .ovf(of_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pop one expected {ovf, acc_out} per handshake.
  always @(negedge clk) begin
    logic [12:0] e;
    if (rst) begin
      if (ov_d && out_ready) begin
        n_checks++;
        if (q_d.size() == 0) begin
          n_errors++;
          $display("FAIL sb_d unexpected result %0d", ao_d);
        end else begin
          e = q_d.pop_front();
          if ({of_d, ao_d} !== e) begin
            n_errors++;
            $display("FAIL sb_d got ovf=%0b acc=%0d want ovf=%0b acc=%0d",
                     of_d, ao_d, e[12], e[11:0]);
          end
        end
      end
      if (ov_w && out_ready) begin
        n_checks++;
        if (q_w.size() == 0) begin
          n_errors++;
          $display("FAIL sb_w unexpected result %0d", ao_w);
        end else begin
          e = q_w.pop_front();
          if ({of_w, 4'b0, ao_w} !== e) begin
            n_errors++;
            $display("FAIL sb_w got ovf=%0b acc=%0d want ovf=%0b acc=%0d",
                     of_w, ao_w, e[12], e[11:0]);
          end
        end
      end
      if (ov_s && out_ready) begin
        n_checks++;
        if (q_s.size() == 0) begin
          n_errors++;
          $display("FAIL sb_s unexpected result %0d", ao_s);
        end else begin
          e = q_s.pop_front();
          if ({of_s, 4'b0, ao_s} !== e) begin
            n_errors++;
            $display("FAIL sb_s got ovf=%0b acc=%0h want ovf=%0b acc=%0h",
                     of_s, ao_s, e[12], e[11:0]);
          end
        end
      end
    end
  end

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [7:0] v);
    int w;
    w = 0;
    in_valid = 1'b1;
    acc_in   = v;
    @(negedge clk);
    while (!cur_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    n_checks++;
    if (!cur_ready) begin
      n_errors++;
      $display("FAIL send_timeout in_ready=%0b want 1", cur_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ar_d, cnt_d, ov_d, ao_d, of_d} !== '0) begin
      n_errors++;
      $display("FAIL reset run=%0d cnt=%0d ov=%0b out=%0d ovf=%0b want 0",
               ar_d, cnt_d, ov_d, ao_d, of_d);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    sel = 0;
    out_ready = 1'b1;
    sat_en = 1'b0;
    q_d.push_back({1'b0, 12'd45});
    q_d.push_back({1'b0, 12'd45});
    repeat (9) send(8'd5);
    n_checks++;
    if (ov_d !== 1'b1 || ao_d !== 12'd45 || of_d !== 1'b0 ||
        cnt_d !== 4'd0 || ar_d !== 12'd0) begin
      n_errors++;
      $display("FAIL win1_latency ov=%0b out=%0d ovf=%0b cnt=%0d run=%0d want 1 45 0 0 0",
               ov_d, ao_d, of_d, cnt_d, ar_d);
    end
    repeat (9) send(8'd5);
    n_checks++;
    if (ov_d !== 1'b1 || ao_d !== 12'd45) begin
      n_errors++;
      $display("FAIL win2_latency ov=%0b out=%0d want 1 45", ov_d, ao_d);
    end
    idle(1);
    n_checks++;
    if (ov_d !== 1'b0 || q_d.size() != 0) begin
      n_errors++;
      $display("FAIL drain ov=%0b pending=%0d want 0 0", ov_d, q_d.size());
    end
  endtask

  task automatic test_unsigned_ovf;
    sel = 1;
    sat_en = 1'b0;
    q_w.push_back({1'b1, 12'd104});
    repeat (9) send(8'd40);
    idle(2);
    sat_en = 1'b1;
    q_w.push_back({1'b1, 12'd255});
    repeat (9) send(8'd40);
    idle(2);
    n_checks++;
    if (q_w.size() != 0) begin
      n_errors++;
      $display("FAIL unsigned_drain pending=%0d want 0", q_w.size());
    end
  endtask

  task automatic test_signed;
    sel = 2;
    sat_en = 1'b1;
    q_s.push_back({1'b1, 12'h080});
    repeat (9) send(8'hEC);
    idle(2);
    q_s.push_back({1'b0, 12'h00A});
    for (int i = 0; i < 9; i++) send((i % 2) ? 8'hF6 : 8'h0A);
    idle(2);
    n_checks++;
    if (q_s.size() != 0) begin
      n_errors++;
      $display("FAIL signed_drain pending=%0d want 0", q_s.size());
    end
  endtask

  task automatic test_backpressure;
    sel = 0;
    sat_en = 1'b0;
    out_ready = 1'b0;
    q_d.push_back({1'b0, 12'd9});
    q_d.push_back({1'b0, 12'd9});
    repeat (9) send(8'd1);
    repeat (8) send(8'd1);
    in_valid = 1'b1;
    acc_in = 8'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (ir_d !== 1'b0 || ar_d !== 12'd8 || cnt_d !== 4'd8 ||
          ov_d !== 1'b1 || ao_d !== 12'd9) begin
        n_errors++;
        $display("FAIL stall ir=%0b run=%0d cnt=%0d ov=%0b out=%0d want 0 8 8 1 9",
                 ir_d, ar_d, cnt_d, ov_d, ao_d);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (ov_d !== 1'b1 || ao_d !== 12'd9 || cnt_d !== 4'd0) begin
      n_errors++;
      $display("FAIL swap ov=%0b out=%0d cnt=%0d want 1 9 0", ov_d, ao_d, cnt_d);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ov_d !== 1'b0 || q_d.size() != 0) begin
      n_errors++;
      $display("FAIL bp_drain ov=%0b pending=%0d want 0 0", ov_d, q_d.size());
    end
  endtask

  task automatic test_clear;
    sel = 0;
    out_ready = 1'b0;
    q_d.push_back({1'b0, 12'd18});
    repeat (9) send(8'd2);
    repeat (4) send(8'd3);
    clear = 1'b1;
    in_valid = 1'b1;
    acc_in = 8'd7;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (ar_d !== 12'd0 || cnt_d !== 4'd0 || ov_d !== 1'b1 || ao_d !== 12'd18) begin
      n_errors++;
      $display("FAIL clear run=%0d cnt=%0d ov=%0b out=%0d want 0 0 1 18",
               ar_d, cnt_d, ov_d, ao_d);
    end
    out_ready = 1'b1;
    q_d.push_back({1'b0, 12'd9});
    repeat (9) send(8'd1);
    idle(2);
    n_checks++;
    if (q_d.size() != 0) begin
      n_errors++;
      $display("FAIL clear_drain pending=%0d want 0", q_d.size());
    end
  endtask

  task automatic test_async_reset;
    sel = 0;
    out_ready = 1'b0;
    repeat (9) send(8'd1);
    repeat (3) send(8'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ar_d, cnt_d, ov_d, ao_d, of_d} !== '0) begin
      n_errors++;
      $display("FAIL async_reset run=%0d cnt=%0d ov=%0b out=%0d ovf=%0b want 0",
               ar_d, cnt_d, ov_d, ao_d, of_d);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    clear     = 1'b0;
    sat_en    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    acc_in    = '0;
    sel       = 0;
    test_reset;
    test_back_to_back;
    test_unsigned_ovf;
    test_signed;
    test_backpressure;
    test_clear;
    test_async_reset;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
